dp_responder: RTL
=================

Name: dp_responder

Overview:
- Responder end of the datapath instruction interface that client FSMs such as food/agent draw units drive with start_dp, instruction_dp, finished_dp and result_dp.
- Accepts one instruction per start rising edge and decodes the opcode.
- Executes MEMREAD or MEMWRITE against internal simulation-state RAM, or DRAW by issuing a one-cycle pixel write to the VGA adapter.
- Returns finished plus result; sits between the client arbiter/mux and the VGA adapter.

Parameters:
- INSTR_W, 32, instruction width (matches INSTRUCTION_WIDTH).
- RESULT_W, 16, result/data width (matches RESULT_WIDTH).
- ADDR_W, 12, RAM address width; depth is 2**ADDR_W words of RESULT_W.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- SCREEN_W, 160, visible width; used only with the optional feature.
- SCREEN_H, 120, visible height; used only with the optional feature.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- start  in  1  request strobe from the client; clients hold it high for 2 cycles.
- instruction  in  INSTR_W  command word; opcode is in [3:0].
- finished  out  1  high when idle/complete, low while busy.
- result  out  RESULT_W  read data for MEMREAD; 0 for other opcodes.
- vga_x  out  X_W  pixel x to the VGA adapter.
- vga_y  out  Y_W  pixel y to the VGA adapter.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  one-cycle write enable to the VGA adapter.
- bad_op  out  1  sticky flag, set when an undefined opcode is accepted.

Behaviour:
- Instruction formats, LSB first:
  - MEMREAD (opcode 1): {addr[ADDR_W-1:0], opcode}.
  - MEMWRITE (opcode 2): {data[RESULT_W-1:0], addr, opcode}.
  - DRAW (opcode 3): {plot, colour, y, x, opcode}.
  - NOP (opcode 0): no action; completes normally.
  - Undefined opcode bits are ignored.
- Reset values: finished=1, result=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, bad_op=0, state=IDLE, start_q=0.
- Reset does not clear RAM contents.
- Reset mid-operation aborts the operation. A MEMWRITE whose write cycle has not occurred is not performed.
- Accept rule: acceptance requires state=IDLE, start=1 and start_q=0 (rising edge). start_q is start registered every cycle.
  - A start still held high after completion never re-triggers.
  - start held high out of reset is accepted once.
- FSM states:
  - IDLE: on accept, latch instruction into instr_q, set finished<=0, go to EXEC.
  - EXEC, MEMREAD: drive RAM read at addr, go to MEM_WAIT.
  - EXEC, MEMWRITE: write data to addr, result<=0, go to DONE.
  - EXEC, DRAW: register x/y/colour onto vga_*, vga_plot<=instr plot bit, result<=0, go to DONE.
  - EXEC, NOP: result<=0, go to DONE.
  - EXEC, undefined opcode: result<=0, bad_op<=1, go to DONE.
  - MEM_WAIT: result<=RAM q (1-cycle synchronous read), go to DONE.
  - DONE: finished<=1, vga_plot<=0, go to IDLE.
- Latency: let E be the accept edge; finished goes low after E.
  - finished rises after E+2 for write, draw, NOP and undefined opcodes.
  - finished rises after E+3 for MEMREAD.
  - This guarantees finished is low in the client's first WAIT sample, because the client's start is registered and held 2 cycles.
- vga_plot is high for exactly one cycle per DRAW with plot=1. vga_x, vga_y and vga_colour hold their values until the next DRAW.
- result is stable from finished rising until the next accept.
- Read-after-write to the same address returns the new data, because the write completes before the next accept.
- Addresses wrap modulo 2**ADDR_W (upper bits truncated).
- start pulses while busy are ignored; no queueing.

Optional Feature:
- Macro: DP_DRAW_CLIP_EN.
- Defined: a DRAW with x>=SCREEN_W or y>=SCREEN_H forces vga_plot=0 and vga_* unchanged; latency is unchanged and finished still rises.
- Undefined: coordinates pass through unchecked.

Decomposition:
- Shared constants header:
  - opcode values OPCODE_NOP, OPCODE_MEMREAD, OPCODE_MEMWRITE, OPCODE_DRAW;
  - opcode width 4;
  - field offsets for each instruction format;
  - state encodings DPR_ST_IDLE, DPR_ST_EXEC, DPR_ST_MEM_WAIT, DPR_ST_DONE.
- Sub-module dp_ram: single-port synchronous RAM (we, addr, d, q), 1-cycle read latency, inferable to block RAM.

Test Plan:
- Reset with resetn=0 for 2 cycles -> finished=1, vga_plot=0, result=0, bad_op=0.
- MEMWRITE addr 0x005 data 0x00A7, then MEMREAD 0x005 -> finished low after accept; read finished rises 3 cycles after accept with result=0x00A7.
- DRAW plot=1 colour=3'b010 x=42 y=17, start held 2 cycles -> exactly one vga_plot pulse with vga_x=42, vga_y=17; single completion; no re-trigger from the held start.
- DRAW with plot=0 -> no vga_plot pulse; finished rises 2 cycles after accept.
- Undefined opcode 4'hF -> bad_op=1 stays set; result=0; finished recovers.
- resetn low during MEM_WAIT -> finished=1 and state IDLE next cycle; RAM word at 0x005 still reads 0x00A7.
- With DP_DRAW_CLIP_EN defined, DRAW x=200 -> no vga_plot; finished still rises.

Source files
------------

// File: rtl/dp_responder_pkg.sv
// ============================================================================
// Module : dp_responder_pkg
// Brief  : Shared opcodes, field offsets and FSM encodings for dp_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dp_responder_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP      = 4'd0;
  localparam logic [OPCODE_W-1:0] OPCODE_MEMREAD  = 4'd1;
  localparam logic [OPCODE_W-1:0] OPCODE_MEMWRITE = 4'd2;
  localparam logic [OPCODE_W-1:0] OPCODE_DRAW     = 4'd3;

  // Every format places its first field directly above the opcode; later
  // fields are stacked on top using the configured widths.
  localparam int OFF_OPCODE  = 0;
  localparam int OFF_RD_ADDR = OPCODE_W;
  localparam int OFF_WR_ADDR = OPCODE_W;
  localparam int OFF_DRAW_X  = OPCODE_W;

  typedef enum logic [1:0] {
    DPR_ST_IDLE     = 2'd0,
    DPR_ST_EXEC     = 2'd1,
    DPR_ST_MEM_WAIT = 2'd2,
    DPR_ST_DONE     = 2'd3
  } dpr_state_e;

endpackage

`default_nettype wire

// File: rtl/dp_ram.sv
// ============================================================================
// Module : dp_ram
// Brief  : Single-port synchronous RAM, one-cycle read latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dp_ram
  import dp_responder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;

  // Read-first: a read in the write cycle returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= d_i;
    end
    rd_q <= mem_q[addr_i];
  end

  assign q_o = rd_q;

endmodule

`default_nettype wire

// File: rtl/dp_responder.sv
// ============================================================================
// Module : dp_responder
// Brief  : Datapath instruction responder: RAM read/write and VGA pixel draw.
//          Define DP_DRAW_CLIP_EN to suppress off-screen DRAW commands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dp_responder
  import dp_responder_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int RESULT_W = 16,
  parameter int ADDR_W   = 12,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  output logic                finished,
  output logic [RESULT_W-1:0] result,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                bad_op
);

  localparam int OFF_WR_DATA     = OFF_WR_ADDR + ADDR_W;
  localparam int OFF_DRAW_Y      = OFF_DRAW_X + X_W;
  localparam int OFF_DRAW_COLOUR = OFF_DRAW_Y + Y_W;
  localparam int OFF_DRAW_PLOT   = OFF_DRAW_COLOUR + COLOUR_W;

  dpr_state_e          state_q;
  logic                start_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                finished_q;
  logic [RESULT_W-1:0] result_q;
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                vga_plot_q;
  logic                bad_op_q;

  logic [OPCODE_W-1:0] w_opcode;
  logic [ADDR_W-1:0]   w_addr;
  logic [RESULT_W-1:0] w_wdata;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic [COLOUR_W-1:0] w_colour;
  logic                w_plot;
  logic                w_in_bounds;
  logic                w_draw_ok;
  logic                w_ram_we;
  logic [RESULT_W-1:0] w_ram_q;
  logic                w_accept;

  assign w_opcode = instr_q[OFF_OPCODE +: OPCODE_W];
  assign w_addr   = instr_q[OFF_RD_ADDR +: ADDR_W];
  assign w_wdata  = instr_q[OFF_WR_DATA +: RESULT_W];
  assign w_x      = instr_q[OFF_DRAW_X +: X_W];
  assign w_y      = instr_q[OFF_DRAW_Y +: Y_W];
  assign w_colour = instr_q[OFF_DRAW_COLOUR +: COLOUR_W];
  assign w_plot   = instr_q[OFF_DRAW_PLOT];

  assign w_in_bounds = (32'(w_x) < SCREEN_W) && (32'(w_y) < SCREEN_H);

`ifdef DP_DRAW_CLIP_EN
  assign w_draw_ok = w_in_bounds;
`else
  logic w_unused_bounds;
  assign w_unused_bounds = w_in_bounds;
  assign w_draw_ok       = 1'b1;
`endif

  assign w_accept = (state_q == DPR_ST_IDLE) && start && !start_q;

  // Gating with resetn keeps an aborted MEMWRITE from landing in RAM.
  assign w_ram_we = resetn && (state_q == DPR_ST_EXEC) && (w_opcode == OPCODE_MEMWRITE);

  dp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (RESULT_W)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (w_ram_we),
    .addr_i (w_addr),
    .d_i    (w_wdata),
    .q_o    (w_ram_q)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= DPR_ST_IDLE;
      start_q      <= 1'b0;
      instr_q      <= '0;
      finished_q   <= 1'b1;
      result_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      bad_op_q     <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        DPR_ST_IDLE: begin
          if (w_accept) begin
            instr_q    <= instruction;
            finished_q <= 1'b0;
            state_q    <= DPR_ST_EXEC;
          end
        end
        DPR_ST_EXEC: begin
          case (w_opcode)
            OPCODE_MEMREAD: begin
              state_q <= DPR_ST_MEM_WAIT;
            end
            OPCODE_MEMWRITE: begin
              result_q <= '0;
              state_q  <= DPR_ST_DONE;
            end
            OPCODE_DRAW: begin
              if (w_draw_ok) begin
                vga_x_q      <= w_x;
                vga_y_q      <= w_y;
                vga_colour_q <= w_colour;
                vga_plot_q   <= w_plot;
              end else begin
                vga_plot_q   <= 1'b0;
              end
              result_q <= '0;
              state_q  <= DPR_ST_DONE;
            end
            OPCODE_NOP: begin
              result_q <= '0;
              state_q  <= DPR_ST_DONE;
            end
            default: begin
              result_q <= '0;
              bad_op_q <= 1'b1;
              state_q  <= DPR_ST_DONE;
            end
          endcase
        end
        DPR_ST_MEM_WAIT: begin
          result_q <= w_ram_q;
          state_q  <= DPR_ST_DONE;
        end
        DPR_ST_DONE: begin
          finished_q <= 1'b1;
          vga_plot_q <= 1'b0;
          state_q    <= DPR_ST_IDLE;
        end
        default: begin
          state_q <= DPR_ST_IDLE;
        end
      endcase
    end
  end

  assign finished   = finished_q;
  assign result     = result_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign bad_op     = bad_op_q;

endmodule

`default_nettype wire
